// File: rtl/timer_display_n.sv
`default_nettype none
// ============================================================================
//  Module      : timer_display_n
//  Description : Parametrised BCD up/down timer with preset load, lap freeze,
//                optional leading-zero blanking, sticky wrap/expiry flag and
//                active-low seven-segment outputs ({a,b,c,d,e,f,g,dp}).
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_display_n #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50_000_000,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dir,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  lap,
    output logic [8*DIGITS-1:0]   seg,
    output logic                  light,
    output logic                  running
);

    localparam int                c_PW   = $clog2(TICK_DIV);
    localparam logic [c_PW-1:0]   c_PMAX = c_PW'(TICK_DIV - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RUN     = 2'd1;
    localparam logic [1:0] c_ST_PAUSE   = 2'd2;
    localparam logic [1:0] c_ST_EXPIRED = 2'd3;

    logic [1:0]            r_state;
    logic [4*DIGITS-1:0]   r_count;
    logic [c_PW-1:0]       r_presc;
    logic                  r_light;
    logic                  r_lap_q;
    logic [4*DIGITS-1:0]   r_lap_cnt;
    logic [8*DIGITS-1:0]   r_seg;

    logic [4*DIGITS-1:0]   w_preset_cl;
    logic [4*DIGITS-1:0]   w_cnt_up;
    logic [4*DIGITS-1:0]   w_cnt_dn;
    logic                  w_carry;
    logic                  w_borrow;
    logic                  w_tick;
    logic                  w_zero;
    logic                  w_expire;
    logic [4*DIGITS-1:0]   w_disp;

    // Active-low glyph for one BCD digit; non-decimal codes show blank.
    function automatic logic [7:0] f_glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'h03;
            4'd1:    g = 8'h9F;
            4'd2:    g = 8'h25;
            4'd3:    g = 8'h0D;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h49;
            4'd6:    g = 8'h41;
            4'd7:    g = 8'h1F;
            4'd8:    g = 8'h01;
            4'd9:    g = 8'h09;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    // Decode every digit, blanking zero digits above the most significant
    // non-zero one when leading-zero blanking is enabled (digit 0 always shown).
    function automatic logic [8*DIGITS-1:0] f_decode(input logic [4*DIGITS-1:0] v);
        logic [8*DIGITS-1:0] o;
        logic                nz;
        o  = '1;
        nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz = nz | (v[4*i +: 4] != 4'd0);
            if ((BLANK_LZ != 0) && (i != 0) && !nz)
                o[8*i +: 8] = 8'hFF;
            else
                o[8*i +: 8] = f_glyph(v[4*i +: 4]);
        end
        return o;
    endfunction

    // Preset digits above 9 are clamped so the count always stays valid BCD.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_clamp
            assign w_preset_cl[4*gi +: 4] = (preset[4*gi +: 4] > 4'd9) ? 4'd9 : preset[4*gi +: 4];
        end
    endgenerate

    // Ripple carry (increment) and ripple borrow (decrement) across BCD digits.
    always_comb begin
        w_cnt_up = r_count;
        w_cnt_dn = r_count;
        w_carry  = 1'b1;
        w_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_cnt_up[4*i +: 4] = 4'd0;
                end else begin
                    w_cnt_up[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry            = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_cnt_dn[4*i +: 4] = 4'd9;
                end else begin
                    w_cnt_dn[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    w_borrow           = 1'b0;
                end
            end
        end
    end

    assign w_tick   = (r_state == c_ST_RUN) && (r_presc == c_PMAX);
    assign w_zero   = (r_count == '0);
    // A down tick from 0 or from 1 ends in the expired state.
    assign w_expire = w_tick && dir && (w_zero || (w_cnt_dn == '0));

    // State machine, prescaler, count and sticky flag (load outranks tick).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_count <= '0;
            r_presc <= '0;
            r_light <= 1'b0;
        end else if (load) begin
            r_count <= w_preset_cl;
            r_presc <= '0;
            r_light <= 1'b0;
            if (r_state == c_ST_EXPIRED)
                r_state <= start ? c_ST_RUN : c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start)
                        r_state <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (w_tick) begin
                        if (dir) begin
                            if (!w_zero)
                                r_count <= w_cnt_dn;
                        end else begin
                            r_count <= w_cnt_up;
                        end
                        if (w_expire || (!dir && w_carry))
                            r_light <= 1'b1;
                    end
                    if (w_expire) begin
                        r_state <= c_ST_EXPIRED;
                        r_presc <= '0;
                    end else if (!start) begin
                        r_state <= c_ST_PAUSE;
                        r_presc <= '0;
                    end else begin
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                    end
                end
                c_ST_PAUSE: begin
                    if (start)
                        r_state <= c_ST_RUN;
                end
                c_ST_EXPIRED: begin
                    r_state <= c_ST_EXPIRED;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Frozen once lap has been high for more than one cycle; the rising-edge
    // cycle itself still passes the live count through.
    assign w_disp = (lap && r_lap_q) ? r_lap_cnt : r_count;

    // Lap capture and registered segment decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lap_q   <= 1'b0;
            r_lap_cnt <= '0;
            r_seg     <= f_decode('0);
        end else begin
            r_lap_q <= lap;
            if (lap && !r_lap_q)
                r_lap_cnt <= r_count;
            r_seg <= f_decode(w_disp);
        end
    end

    assign seg     = r_seg;
    assign light   = r_light;
    assign running = (r_state == c_ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_timer_display_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_display_n
//  Description : Directed self-checking bench for timer_display_n with
//                DIGITS=2, TICK_DIV=4; one instance without and one with
//                leading-zero blanking, both driven by the same inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_display_n;

    logic        clk;
    logic        rst;
    logic        start;
    logic        dir;
    logic        load;
    logic [7:0]  preset;
    logic        lap;
    logic [15:0] seg;
    logic [15:0] seg_lz;
    logic        light;
    logic        light_lz;
    logic        running;
    logic        running_lz;

    int n_checks;
    int n_errors;

    timer_display_n #(.DIGITS(2), .TICK_DIV(4), .BLANK_LZ(0)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .load(load),
        .preset(preset), .lap(lap), .seg(seg), .light(light), .running(running)
    );

    timer_display_n #(.DIGITS(2), .TICK_DIV(4), .BLANK_LZ(1)) dut_lz (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .load(load),
        .preset(preset), .lap(lap), .seg(seg_lz), .light(light_lz), .running(running_lz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written active-low glyphs {a,b,c,d,e,f,g,dp}.
    function automatic logic [7:0] glyph(input int d);
        case (d)
            0: return 8'h03;
            1: return 8'h9F;
            2: return 8'h25;
            3: return 8'h0D;
            4: return 8'h99;
            5: return 8'h49;
            6: return 8'h41;
            7: return 8'h1F;
            8: return 8'h01;
            9: return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected two-digit segment word for decimal value v.
    function automatic logic [15:0] exp_seg(input int v, input bit lz);
        logic [7:0] hi;
        hi = (lz && (v < 10)) ? 8'hFF : glyph(v / 10);
        return {hi, glyph(v % 10)};
    endfunction

    // Advance n clock edges, landing 1 time unit after the last edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dir = 1'b0; load = 1'b0; preset = 8'h00; lap = 1'b0;
        cyc(2);
        n_checks++;
        if (seg !== 16'h0303) begin n_errors++; $display("FAIL reset_seg got %h expected %h", seg, 16'h0303); end
        n_checks++;
        if (seg_lz !== 16'hFF03) begin n_errors++; $display("FAIL reset_seg_lz got %h expected %h", seg_lz, 16'hFF03); end
        n_checks++;
        if (light !== 1'b0) begin n_errors++; $display("FAIL reset_light got %b expected 0", light); end
        n_checks++;
        if (running !== 1'b0) begin n_errors++; $display("FAIL reset_running got %b expected 0", running); end
    endtask

    task automatic test_count_up();
        rst = 1'b0; start = 1'b1;
        cyc(2);
        n_checks++;
        if (running !== 1'b1) begin n_errors++; $display("FAIL up_running got %b expected 1", running); end
        n_checks++;
        if (seg !== 16'h0303) begin n_errors++; $display("FAIL up_seg k=0 got %h expected %h", seg, 16'h0303); end
        for (int k = 1; k <= 10; k++) begin
            cyc(4);
            n_checks++;
            if (seg !== exp_seg(k, 1'b0)) begin n_errors++; $display("FAIL up_seg k=%0d got %h expected %h", k, seg, exp_seg(k, 1'b0)); end
            n_checks++;
            if (seg_lz !== exp_seg(k, 1'b1)) begin n_errors++; $display("FAIL up_seg_lz k=%0d got %h expected %h", k, seg_lz, exp_seg(k, 1'b1)); end
        end
        n_checks++;
        if (seg !== 16'h9F03) begin n_errors++; $display("FAIL up_seg_10 got %h expected 9f03", seg); end
        n_checks++;
        if (light !== 1'b0) begin n_errors++; $display("FAIL up_light got %b expected 0", light); end
    endtask

    task automatic test_wrap();
        dir = 1'b0; preset = 8'h99; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(1);
        n_checks++;
        if (seg !== exp_seg(99, 1'b0)) begin n_errors++; $display("FAIL wrap_load_seg got %h expected %h", seg, exp_seg(99, 1'b0)); end
        n_checks++;
        if (light !== 1'b0) begin n_errors++; $display("FAIL wrap_light_pre got %b expected 0", light); end
        cyc(3);
        n_checks++;
        if (light !== 1'b1) begin n_errors++; $display("FAIL wrap_light got %b expected 1", light); end
        cyc(1);
        n_checks++;
        if (seg !== exp_seg(0, 1'b0)) begin n_errors++; $display("FAIL wrap_seg got %h expected %h", seg, exp_seg(0, 1'b0)); end
        n_checks++;
        if (seg_lz !== exp_seg(0, 1'b1)) begin n_errors++; $display("FAIL wrap_seg_lz got %h expected %h", seg_lz, exp_seg(0, 1'b1)); end
        cyc(4);
        n_checks++;
        if (seg !== exp_seg(1, 1'b0)) begin n_errors++; $display("FAIL wrap_next_seg got %h expected %h", seg, exp_seg(1, 1'b0)); end
        n_checks++;
        if (light !== 1'b1) begin n_errors++; $display("FAIL wrap_light_sticky got %b expected 1", light); end
    endtask

    task automatic test_expire();
        dir = 1'b1; preset = 8'h02; load = 1'b1;
        cyc(1);
        load = 1'b0;
        n_checks++;
        if (light !== 1'b0) begin n_errors++; $display("FAIL exp_light_cleared got %b expected 0", light); end
        cyc(5);
        n_checks++;
        if (seg !== exp_seg(1, 1'b0)) begin n_errors++; $display("FAIL exp_seg01 got %h expected %h", seg, exp_seg(1, 1'b0)); end
        n_checks++;
        if (seg_lz !== exp_seg(1, 1'b1)) begin n_errors++; $display("FAIL exp_seg01_lz got %h expected %h", seg_lz, exp_seg(1, 1'b1)); end
        n_checks++;
        if (running !== 1'b1) begin n_errors++; $display("FAIL exp_running_pre got %b expected 1", running); end
        cyc(3);
        n_checks++;
        if (running !== 1'b0) begin n_errors++; $display("FAIL exp_running got %b expected 0", running); end
        n_checks++;
        if (light !== 1'b1) begin n_errors++; $display("FAIL exp_light got %b expected 1", light); end
        cyc(1);
        n_checks++;
        if (seg !== exp_seg(0, 1'b0)) begin n_errors++; $display("FAIL exp_seg00 got %h expected %h", seg, exp_seg(0, 1'b0)); end
        cyc(8);
        n_checks++;
        if (seg !== exp_seg(0, 1'b0)) begin n_errors++; $display("FAIL exp_hold_seg got %h expected %h", seg, exp_seg(0, 1'b0)); end
        n_checks++;
        if (running !== 1'b0) begin n_errors++; $display("FAIL exp_hold_running got %b expected 0", running); end
    endtask

    task automatic test_pause();
        dir = 1'b0; preset = 8'h00; load = 1'b1;
        cyc(1);
        load = 1'b0;
        n_checks++;
        if (running !== 1'b1) begin n_errors++; $display("FAIL pause_restart_running got %b expected 1", running); end
        cyc(2);
        start = 1'b0;
        cyc(1);
        n_checks++;
        if (running !== 1'b0) begin n_errors++; $display("FAIL pause_running got %b expected 0", running); end
        cyc(6);
        n_checks++;
        if (seg !== exp_seg(0, 1'b0)) begin n_errors++; $display("FAIL pause_hold_seg got %h expected %h", seg, exp_seg(0, 1'b0)); end
        start = 1'b1;
        cyc(4);
        n_checks++;
        if (seg !== exp_seg(0, 1'b0)) begin n_errors++; $display("FAIL pause_no_early_tick got %h expected %h", seg, exp_seg(0, 1'b0)); end
        cyc(2);
        n_checks++;
        if (seg !== exp_seg(1, 1'b0)) begin n_errors++; $display("FAIL pause_full_period got %h expected %h", seg, exp_seg(1, 1'b0)); end
    endtask

    task automatic test_lap();
        cyc(15);
        lap = 1'b1;
        cyc(1);
        n_checks++;
        if (seg !== exp_seg(5, 1'b0)) begin n_errors++; $display("FAIL lap_capture got %h expected %h", seg, exp_seg(5, 1'b0)); end
        cyc(12);
        n_checks++;
        if (seg !== exp_seg(5, 1'b0)) begin n_errors++; $display("FAIL lap_frozen got %h expected %h", seg, exp_seg(5, 1'b0)); end
        n_checks++;
        if (seg_lz !== exp_seg(5, 1'b1)) begin n_errors++; $display("FAIL lap_frozen_lz got %h expected %h", seg_lz, exp_seg(5, 1'b1)); end
        lap = 1'b0;
        cyc(1);
        n_checks++;
        if (seg !== exp_seg(8, 1'b0)) begin n_errors++; $display("FAIL lap_release got %h expected %h", seg, exp_seg(8, 1'b0)); end
    endtask

    task automatic test_clamp_and_collision();
        preset = 8'hA3; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(1);
        n_checks++;
        if (seg !== 16'h090D) begin n_errors++; $display("FAIL clamp_seg got %h expected 090d", seg); end
        n_checks++;
        if (seg_lz !== 16'h090D) begin n_errors++; $display("FAIL clamp_seg_lz got %h expected 090d", seg_lz); end
        cyc(2);
        preset = 8'h03; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(1);
        n_checks++;
        if (seg !== 16'h030D) begin n_errors++; $display("FAIL collide_seg got %h expected 030d", seg); end
        n_checks++;
        if (seg_lz !== 16'hFF0D) begin n_errors++; $display("FAIL collide_seg_lz got %h expected ff0d", seg_lz); end
        cyc(4);
        n_checks++;
        if (seg !== exp_seg(4, 1'b0)) begin n_errors++; $display("FAIL collide_next got %h expected %h", seg, exp_seg(4, 1'b0)); end
    endtask

    task automatic test_reset_mid_run();
        lap = 1'b1;
        cyc(2);
        rst = 1'b1; lap = 1'b0;
        cyc(1);
        n_checks++;
        if (seg !== 16'h0303) begin n_errors++; $display("FAIL midrst_seg got %h expected 0303", seg); end
        n_checks++;
        if (seg_lz !== 16'hFF03) begin n_errors++; $display("FAIL midrst_seg_lz got %h expected ff03", seg_lz); end
        n_checks++;
        if (running !== 1'b0) begin n_errors++; $display("FAIL midrst_running got %b expected 0", running); end
        rst = 1'b0; start = 1'b0;
        cyc(3);
        n_checks++;
        if (running !== 1'b0) begin n_errors++; $display("FAIL midrst_idle got %b expected 0", running); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_count_up();
        test_wrap();
        test_expire();
        test_pause();
        test_lap();
        test_clamp_and_collision();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
